// File: rtl/cnn_layer_accel_rd_arbiter.sv
// cnn_layer_accel_rd_arbiter: round-robin arbiter that gives N read clients one shared memory read port,
// with one transaction outstanding at a time.
module cnn_layer_accel_rd_arbiter #(
    parameter int NUM_RD_CLIENTS = 4,
    parameter int INIT_ID_WTH    = 4,
    parameter int INIT_ADDR_WTH  = 32,
    parameter int INIT_LEN_WTH   = 16,
    parameter int INIT_DATA_WTH  = 512
) (
    input  logic                                      clk_intf,
    input  logic                                      rst,
    input  logic [NUM_RD_CLIENTS-1:0]                 init_rd_req,
    input  logic [NUM_RD_CLIENTS*INIT_ID_WTH-1:0]     init_rd_req_id,
    input  logic [NUM_RD_CLIENTS*INIT_ADDR_WTH-1:0]   init_rd_addr,
    input  logic [NUM_RD_CLIENTS*INIT_LEN_WTH-1:0]    init_rd_len,
    output logic [NUM_RD_CLIENTS-1:0]                 init_rd_req_ack,
    output logic [NUM_RD_CLIENTS*INIT_DATA_WTH-1:0]   init_rd_data,
    output logic [NUM_RD_CLIENTS-1:0]                 init_rd_data_vld,
    input  logic [NUM_RD_CLIENTS-1:0]                 init_rd_data_rdy,
    output logic [NUM_RD_CLIENTS-1:0]                 init_rd_cmpl,
    output logic                                      mem_rd_req,
    output logic [INIT_ID_WTH-1:0]                    mem_rd_id,
    output logic [INIT_ADDR_WTH-1:0]                  mem_rd_addr,
    output logic [INIT_LEN_WTH-1:0]                   mem_rd_len,
    input  logic                                      mem_rd_req_ack,
    input  logic [INIT_DATA_WTH-1:0]                  mem_rd_data,
    input  logic                                      mem_rd_data_vld,
    output logic                                      mem_rd_data_rdy
);
    localparam int N  = NUM_RD_CLIENTS;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, XFER, CMPL} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     rr_ptr, grant, sel, lo_sel, hi_sel;
    logic              hi_hit, any_req, beat;
    logic [N-1:0]      grant_oh;
    logic [INIT_LEN_WTH-1:0] cnt;

    // Prefer the lowest requester at or above rr_ptr; otherwise wrap to the lowest overall.
    always_comb begin
        lo_sel = '0;
        hi_sel = '0;
        hi_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (init_rd_req[i]) lo_sel = GW'(i);
            if (init_rd_req[i] && GW'(i) >= rr_ptr) begin
                hi_sel = GW'(i);
                hi_hit = 1'b1;
            end
        end
    end

    assign sel      = hi_hit ? hi_sel : lo_sel;
    assign any_req  = |init_rd_req;
    assign grant_oh = N'(1) << grant;
    assign beat     = mem_rd_data_vld && mem_rd_data_rdy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? GRANT : IDLE;
            GRANT:   state_nxt = (mem_rd_len == '0) ? CMPL : ISSUE;
            ISSUE:   state_nxt = mem_rd_req_ack ? XFER : ISSUE;
            XFER:    state_nxt = (beat && cnt == INIT_LEN_WTH'(1)) ? CMPL : XFER;
            CMPL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_intf or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            cnt         <= '0;
            mem_rd_id   <= '0;
            mem_rd_addr <= '0;
            mem_rd_len  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant       <= sel;
                mem_rd_id   <= init_rd_req_id[sel*INIT_ID_WTH +: INIT_ID_WTH];
                mem_rd_addr <= init_rd_addr[sel*INIT_ADDR_WTH +: INIT_ADDR_WTH];
                mem_rd_len  <= init_rd_len[sel*INIT_LEN_WTH +: INIT_LEN_WTH];
            end
            if (state == GRANT)
                rr_ptr <= (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
            if (state == ISSUE && mem_rd_req_ack)
                cnt <= mem_rd_len;
            else if (state == XFER && beat)
                cnt <= cnt - 1'b1;
        end
    end

    assign init_rd_req_ack  = (state == GRANT) ? grant_oh : '0;
    assign init_rd_cmpl     = (state == CMPL) ? grant_oh : '0;
    assign init_rd_data_vld = (state == XFER && mem_rd_data_vld) ? grant_oh : '0;
    assign mem_rd_data_rdy  = (state == XFER) && init_rd_data_rdy[grant];
    assign mem_rd_req       = (state == ISSUE);

    // Data is steered only to the granted slice; all other slices read as zero.
    always_comb begin
        init_rd_data = '0;
        if (state == XFER) init_rd_data[grant*INIT_DATA_WTH +: INIT_DATA_WTH] = mem_rd_data;
    end
endmodule

// File: tb/tb_cnn_layer_accel_rd_arbiter.sv
// tb_cnn_layer_accel_rd_arbiter: scoreboard bench with a round-robin reference model, a randomized
// memory responder and randomized client backpressure.
module tb_cnn_layer_accel_rd_arbiter;
    localparam int N = 4, IW = 4, AW = 32, LW = 16, DW = 512;

    logic              clk_intf = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      init_rd_req = '0;
    logic [N*IW-1:0]   init_rd_req_id = '0;
    logic [N*AW-1:0]   init_rd_addr = '0;
    logic [N*LW-1:0]   init_rd_len = '0;
    logic [N-1:0]      init_rd_req_ack;
    logic [N*DW-1:0]   init_rd_data;
    logic [N-1:0]      init_rd_data_vld;
    logic [N-1:0]      init_rd_data_rdy = '0;
    logic [N-1:0]      init_rd_cmpl;
    logic              mem_rd_req;
    logic [IW-1:0]     mem_rd_id;
    logic [AW-1:0]     mem_rd_addr;
    logic [LW-1:0]     mem_rd_len;
    logic              mem_rd_req_ack = 1'b0;
    logic [DW-1:0]     mem_rd_data = '0;
    logic              mem_rd_data_vld = 1'b0;
    logic              mem_rd_data_rdy;

    always #5 clk_intf = ~clk_intf;

    cnn_layer_accel_rd_arbiter #(
        .NUM_RD_CLIENTS(N), .INIT_ID_WTH(IW), .INIT_ADDR_WTH(AW),
        .INIT_LEN_WTH(LW), .INIT_DATA_WTH(DW)
    ) dut (
        .clk_intf(clk_intf), .rst(rst),
        .init_rd_req(init_rd_req), .init_rd_req_id(init_rd_req_id),
        .init_rd_addr(init_rd_addr), .init_rd_len(init_rd_len),
        .init_rd_req_ack(init_rd_req_ack), .init_rd_data(init_rd_data),
        .init_rd_data_vld(init_rd_data_vld), .init_rd_data_rdy(init_rd_data_rdy),
        .init_rd_cmpl(init_rd_cmpl), .mem_rd_req(mem_rd_req), .mem_rd_id(mem_rd_id),
        .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len), .mem_rd_req_ack(mem_rd_req_ack),
        .mem_rd_data(mem_rd_data), .mem_rd_data_vld(mem_rd_data_vld),
        .mem_rd_data_rdy(mem_rd_data_rdy)
    );

    typedef struct {
        int            client;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        int            len;
    } txn_t;

    txn_t ack_q[$], mem_q[$], xfr_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, ack_cyc = 0, last_cyc = 0, issue_cyc = 0, beat_cnt = 0;
    int   model_rr = 0, rdy_mode = 0, mem_mode = 0;
    bit   in_xfer = 0, prev_req = 0, round_first = 0;
    int            t_len [N];
    logic [IW-1:0] t_id  [N];
    logic [AW-1:0] t_addr[N];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int c);
        return N'(1) << c;
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
        logic [31:0] w;
        w = a ^ (32'(i) * 32'h9E3779B9) ^ 32'(i);
        return {(DW/32){w}};
    endfunction

    // Memory responder and client ready generator.
    bit            m_active = 0;
    int            m_rem = 0, m_idx = 0;
    logic [AW-1:0] m_addr = '0;
    initial begin
        forever begin
            @(negedge clk_intf); #1;
            if (!rst) begin
                m_active = 0;
                m_rem = 0;
            end else if (mem_rd_req && mem_rd_req_ack) begin
                m_active = 1;
                m_rem = int'(mem_rd_len);
                m_addr = mem_rd_addr;
                m_idx = 0;
            end else if (m_active && mem_rd_data_vld && mem_rd_data_rdy) begin
                m_idx++;
                m_rem--;
                if (m_rem == 0) m_active = 0;
            end
            @(posedge clk_intf); #1;
            mem_rd_req_ack = mem_rd_req && (mem_mode == 0 || $urandom_range(0, 2) == 0);
            if (m_active) begin
                mem_rd_data_vld = (mem_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                mem_rd_data = beat_data(m_addr, m_idx);
            end else begin
                mem_rd_data_vld = 1'($urandom_range(0, 1));
                mem_rd_data = {(DW/32){$urandom}};
            end
            init_rd_data_rdy = (rdy_mode == 0) ? '1 : (rdy_mode == 1) ? ~init_rd_data_rdy : N'($urandom);
        end
    end

    // Monitor: observes settled values mid-cycle, i.e. what the next rising edge will act on.
    initial begin
        txn_t t;
        logic [N*DW-1:0] exp_vec;
        int c;
        bit xfer_done;
        forever begin
            @(negedge clk_intf); #1;
            cyc++;
            if (!rst) begin
                chk("outputs in reset",
                    {|init_rd_req_ack, |init_rd_cmpl, |init_rd_data_vld, |init_rd_data, mem_rd_req,
                     |mem_rd_id, |mem_rd_addr, |mem_rd_len, mem_rd_data_rdy}, '0);
                ack_q.delete(); mem_q.delete(); xfr_q.delete();
                in_xfer = 0; prev_req = 0; beat_cnt = 0; round_first = 0;
            end else begin
                xfer_done = 0;
                if (init_rd_req_ack != '0) begin
                    if (ack_q.size() == 0) chk("unexpected ack", init_rd_req_ack, '0);
                    else begin
                        t = ack_q.pop_front();
                        chk("ack vector", init_rd_req_ack, oh(t.client));
                        if (round_first) chk("ack latency", cyc - issue_cyc, 2);
                        round_first = 0;
                        ack_cyc = cyc;
                    end
                end
                if (mem_rd_req && !prev_req) begin
                    if (mem_q.size() == 0) chk("unexpected mem req", 1, 0);
                    else begin
                        t = mem_q[0];
                        chk("mem id", mem_rd_id, t.id);
                        chk("mem addr", mem_rd_addr, t.addr);
                        chk("mem len", mem_rd_len, t.len);
                        chk("mem req latency", cyc - ack_cyc, 1);
                    end
                end
                prev_req = mem_rd_req;
                chk("mem rdy", mem_rd_data_rdy, in_xfer ? init_rd_data_rdy[xfr_q[0].client] : 1'b0);
                if (in_xfer) begin
                    c = xfr_q[0].client;
                    chk("vld route", init_rd_data_vld, mem_rd_data_vld ? oh(c) : '0);
                    if (init_rd_data_vld[c] && init_rd_data_rdy[c]) begin
                        exp_vec = '0;
                        exp_vec[c*DW +: DW] = beat_data(xfr_q[0].addr, beat_cnt);
                        n_cmp++;
                        if (init_rd_data !== exp_vec) begin
                            n_err++;
                            $display("FAIL beat data client %0d beat %0d: got %h expected %h",
                                     c, beat_cnt, init_rd_data[c*DW +: 32], exp_vec[c*DW +: 32]);
                        end
                        beat_cnt++;
                        if (beat_cnt == xfr_q[0].len) begin
                            xfer_done = 1;
                            last_cyc = cyc;
                        end
                    end
                end else begin
                    chk("idle vld", init_rd_data_vld, '0);
                    chk("idle data", |init_rd_data, 0);
                end
                if (init_rd_cmpl != '0) begin
                    if (xfr_q.size() == 0) chk("unexpected cmpl", init_rd_cmpl, '0);
                    else begin
                        t = xfr_q.pop_front();
                        chk("cmpl vector", init_rd_cmpl, oh(t.client));
                        chk("beats per txn", beat_cnt, t.len);
                        chk("cmpl latency", cyc - ((t.len == 0) ? ack_cyc : last_cyc), 1);
                        beat_cnt = 0;
                    end
                end
                if (mem_rd_req && mem_rd_req_ack && mem_q.size() > 0) begin
                    void'(mem_q.pop_front());
                    in_xfer = 1;
                end
                if (xfer_done) in_xfer = 0;
            end
        end
    end

    // Reference model: grants follow cyclic priority from the last served client + 1.
    task automatic issue(input logic [N-1:0] mask);
        logic [N-1:0] rem;
        txn_t t;
        @(posedge clk_intf); #1;
        rem = mask;
        while (rem != '0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (model_rr + k) % N;
                if (rem[j]) begin
                    t.client = j; t.id = t_id[j]; t.addr = t_addr[j]; t.len = t_len[j];
                    ack_q.push_back(t);
                    if (t.len > 0) mem_q.push_back(t);
                    xfr_q.push_back(t);
                    rem[j] = 1'b0;
                    model_rr = (j + 1) % N;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            init_rd_req_id[i*IW +: IW] = t_id[i];
            init_rd_addr[i*AW +: AW] = t_addr[i];
            init_rd_len[i*LW +: LW] = LW'(t_len[i]);
        end
        issue_cyc = cyc;
        round_first = 1;
        init_rd_req = mask;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((ack_q.size() + mem_q.size() + xfr_q.size()) != 0 && b < 3000) begin
            @(negedge clk_intf); #2;
            init_rd_req = init_rd_req & ~init_rd_req_ack;
            b++;
        end
        chk("round finished in budget", b < 3000, 1);
    endtask

    task automatic set_all(input int len);
        for (int i = 0; i < N; i++) begin
            t_len[i] = len;
            t_id[i] = IW'(i + 8);
            t_addr[i] = AW'(32'h100 * (i + 1));
        end
    endtask

    initial begin
        int b;
        repeat (3) @(negedge clk_intf);
        #3 rst = 1'b1;
        model_rr = 0;

        // All four request together, each for one beat: grants 0,1,2,3 then 0 again.
        set_all(1);
        issue(4'b1111); wait_idle();
        issue(4'b0001); wait_idle();

        set_all(0);
        t_id[2] = 4'd5; t_addr[2] = 32'h1000; t_len[2] = 4;
        issue(4'b0100); wait_idle();

        // Client ready toggles every cycle while memory streams continuously.
        rdy_mode = 1;
        t_len[0] = 3; t_id[0] = 4'd3; t_addr[0] = 32'h2000;
        issue(4'b0001); wait_idle();
        rdy_mode = 0;

        t_len[1] = 0; t_id[1] = 4'd9; t_addr[1] = 32'h3000;
        issue(4'b0010); wait_idle();

        // Abandon an 8-beat read from client 1 after two beats by resetting.
        t_len[1] = 8; t_id[1] = 4'd7; t_addr[1] = 32'h4000;
        issue(4'b0010);
        b = 0;
        while (beat_cnt < 2 && b < 200) begin
            @(negedge clk_intf); #2;
            init_rd_req = init_rd_req & ~init_rd_req_ack;
            b++;
        end
        chk("reached beat 2", b < 200, 1);
        @(negedge clk_intf); #3;
        rst = 1'b0;
        init_rd_req = '0;
        #1;
        chk("async reset clears outputs",
            {|init_rd_req_ack, |init_rd_cmpl, |init_rd_data_vld, |init_rd_data, mem_rd_req,
             |mem_rd_id, |mem_rd_addr, |mem_rd_len, mem_rd_data_rdy}, '0);
        repeat (3) @(negedge clk_intf);
        #3 rst = 1'b1;
        model_rr = 0;
        set_all(2);
        issue(4'b1111); wait_idle();

        for (int r = 0; r < 40; r++) begin
            rdy_mode = $urandom_range(0, 2);
            mem_mode = $urandom_range(0, 1);
            for (int i = 0; i < N; i++) begin
                t_len[i] = $urandom_range(0, 6);
                t_id[i] = IW'($urandom);
                t_addr[i] = $urandom;
            end
            issue(N'($urandom_range(1, (1 << N) - 1)));
            wait_idle();
        end

        repeat (5) @(negedge clk_intf);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
